pic27_ack_ctrl: RTL and testbench
=================================

Name: pic27_ack_ctrl

Overview:
- Request/acknowledge end of the 27-channel priority interrupt controller.
- Captures 27 source request edges into pending registers and drives the E/A/B/C vectors into the combinational priority controller.
- Decodes the returned PA/PB/PC group flags and 4-bit channel code into a 5-bit vector.
- Runs the CPU irq/ack/EOI handshake and returns a one-cycle acknowledge pulse to the winning source.

Parameters:
- NCH, 9: channels per group; fixed at 9, parameterised for readability only.
- ACK_TO, 64: cycles irq_o may stay asserted without cpu_ack_i before the request is withdrawn.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > ACK_TO.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- src_req_i  in  27  source request lines; bits [8:0] group A, [17:9] group B, [26:18] group C; rising edge = new request.
- en_i  in  9  per-channel enable from CPU config.
- e_o  out  9  registered copy of en_i to the controller E input.
- a_o  out  9  pending group-A vector to the controller.
- b_o  out  9  pending group-B vector to the controller.
- c_o  out  9  pending group-C vector to the controller.
- pa_i  in  1  controller group-A flag.
- pb_i  in  1  controller group-B flag.
- pc_i  in  1  controller group-C flag.
- chan_i  in  4  controller channel code.
- irq_o  out  1  interrupt request to CPU.
- cpu_ack_i  in  1  CPU acknowledge.
- vec_valid_o  out  1  one-cycle strobe; vec_o is valid while high.
- vec_o  out  5  vector = group*9 + n (0..26).
- eoi_i  in  1  CPU end-of-interrupt.
- src_ack_o  out  27  one-hot, one-cycle acknowledge to the serviced source.
- err_o  out  1  sticky illegal-channel-code flag.

Behaviour:
- Reset: all outputs, pending bits and edge-detect history clear to 0; FSM in IDLE.
- Edge capture: a 0->1 transition on src_req_i[k] sets pend[k] on the next clk edge. A level held high sets pend[k] only once.
- Set/clear collision: if a new edge and an ack-clear hit the same bit in the same cycle, the set wins and pend[k] stays 1.
- Pending vectors: a_o/b_o/c_o come straight from the pend flops. e_o is en_i registered once.
- Controller is combinational; its outputs are sampled one cycle after the pend/e_o change (ARB state).
- Channel code: chan_i = 4'd15 - n for channel n = 0..8. Codes 0..6 are illegal.
- Group select: pa_i -> group 0; else pb_i -> group 1; else pc_i -> group 2.
- FSM states and transitions:
  - IDLE: go to ARB when any bit of (pend & {3{e_o}}) is set.
  - ARB (1 cycle):
    - no flag set: back to IDLE.
    - illegal code: set err_o, back to IDLE, no ack.
    - otherwise: latch group/n into vec_r, go to IRQ.
  - IRQ: irq_o=1; the timeout counter runs.
    - cpu_ack_i: go to SVC.
    - counter reaches ACK_TO: irq_o drops, pend unchanged, back to IDLE for re-arbitration.
  - SVC (1 cycle): vec_valid_o=1, vec_o=vec_r, src_ack_o[vec_r]=1, pend[vec_r] cleared (subject to the collision rule); go to INSVC.
  - INSVC: wait for eoi_i, then go to IDLE. No new irq is raised before EOI.
- Stability: vec_r is frozen from ARB to SVC. en_i or src_req_i changes during IRQ do not alter the vector.
- Ignored inputs:
  - cpu_ack_i outside IRQ.
  - eoi_i outside INSVC.
  - eoi_i in the same cycle as SVC; it is not remembered.
- Reset mid-operation drops irq_o and all pending bits immediately (asynchronous).
- Arithmetic: vec = group*9 + n computed in 5 bits; maximum 26, no overflow.
- err_o is cleared only by reset.

Decomposition:
- Package pic27_pkg:
  - NCH, NGRP=3.
  - state enum {IDLE, ARB, IRQ, SVC, INSVC}.
  - group enum {GRP_A, GRP_B, GRP_C}.
  - function chan_code_to_idx (returns n plus a legal bit).
  - function vec_of(group, n).
- One sub-module: pic27_pend_bank — edge detect plus set/clear pending flops for 27 bits, instantiated once.

Test Plan:
- Reset then en_i=9'h1FF, pulse src_req_i[3] -> a_o=9'h008. Controller model returns pa_i=1, chan_i=12 -> irq_o=1. Then cpu_ack_i -> vec_o=3, vec_valid_o 1 cycle, src_ack_o[3] 1 cycle, a_o=0. eoi_i -> IDLE.
- Pulse src_req_i[20] (C, n=2) together with src_req_i[10] (B, n=1); model pb_i=1, chan_i=14 -> vec_o=10. After EOI, next service gives vec_o=20.
- Hold cpu_ack_i low for ACK_TO=64 cycles -> irq_o deasserts at cycle 64, pend bit retained, irq_o re-raised after re-arbitration.
- Model drives pa_i=1, chan_i=4 -> err_o=1, no src_ack_o pulse, irq_o stays 0.
- New edge on src_req_i[5] in the SVC cycle servicing bit 5 -> pend[5] remains 1 and a second irq follows EOI.
- Assert rst_n=0 while in IRQ -> irq_o, a_o/b_o/c_o go 0 without a clock edge.

Source files
------------

// File: rtl/pic27_pkg.sv
// Shared types and helpers for the 27-channel interrupt request/ack front end.
package pic27_pkg;
  localparam int NCH  = 9;
  localparam int NGRP = 3;

  typedef enum logic [2:0] {IDLE, ARB, IRQ, SVC, INSVC} state_t;
  typedef enum logic [1:0] {GRP_A, GRP_B, GRP_C} grp_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] idx;
  } chan_dec_t;

  // Controller encodes channel n as 15-n, so only codes 7..15 name a channel.
  function automatic chan_dec_t chan_code_to_idx(logic [3:0] code);
    chan_dec_t d;
    d.legal = (code >= 4'd7);
    d.idx   = 4'd15 - code;
    return d;
  endfunction

  function automatic logic [4:0] vec_of(grp_t g, logic [3:0] n);
    return 5'(g) * 5'd9 + 5'(n);
  endfunction
endpackage

// File: rtl/pic27_pend_bank.sv
// Rising-edge capture into sticky pending flops; a new edge beats a same-cycle clear.
module pic27_pend_bank #(
  parameter int NB = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] req,
  input  logic [NB-1:0] clr,
  output logic [NB-1:0] pend
);
  logic [NB-1:0] req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | (req & ~req_q);
    end
  end
endmodule

// File: rtl/pic27_ack_ctrl.sv
// CPU irq/ack/EOI handshake around the combinational 27-channel priority controller.
module pic27_ack_ctrl
  import pic27_pkg::*;
#(
  parameter int NCH    = pic27_pkg::NCH,
  parameter int ACK_TO = 64,
  parameter int TO_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NGRP*NCH-1:0]  src_req_i,
  input  logic [NCH-1:0]       en_i,
  output logic [NCH-1:0]       e_o,
  output logic [NCH-1:0]       a_o,
  output logic [NCH-1:0]       b_o,
  output logic [NCH-1:0]       c_o,
  input  logic                 pa_i,
  input  logic                 pb_i,
  input  logic                 pc_i,
  input  logic [3:0]           chan_i,
  output logic                 irq_o,
  input  logic                 cpu_ack_i,
  output logic                 vec_valid_o,
  output logic [4:0]           vec_o,
  input  logic                 eoi_i,
  output logic [NGRP*NCH-1:0]  src_ack_o,
  output logic                 err_o
);
  localparam int NB = NGRP * NCH;

  state_t         st;
  logic [NB-1:0]  pend;
  logic [4:0]     vec_r;
  logic [TO_W-1:0] cnt;
  chan_dec_t      dec;
  grp_t           grp;

  // The ack pulse itself is the clear strobe for the serviced pending bit.
  pic27_pend_bank #(.NB(NB)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (src_req_i),
    .clr   (src_ack_o),
    .pend  (pend)
  );

  assign a_o = pend[NCH-1:0];
  assign b_o = pend[2*NCH-1:NCH];
  assign c_o = pend[3*NCH-1:2*NCH];

  assign dec = chan_code_to_idx(chan_i);
  assign grp = pa_i ? GRP_A : (pb_i ? GRP_B : GRP_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_o <= '0;
    else        e_o <= en_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      irq_o       <= 1'b0;
      vec_valid_o <= 1'b0;
      vec_o       <= '0;
      vec_r       <= '0;
      src_ack_o   <= '0;
      err_o       <= 1'b0;
      cnt         <= '0;
    end else begin
      vec_valid_o <= 1'b0;
      src_ack_o   <= '0;
      case (st)
        IDLE: if (|(pend & {NGRP{e_o}})) st <= ARB;
        ARB: begin
          if (!(pa_i | pb_i | pc_i)) begin
            st <= IDLE;
          end else if (!dec.legal) begin
            err_o <= 1'b1;
            st    <= IDLE;
          end else begin
            vec_r <= vec_of(grp, dec.idx);
            cnt   <= '0;
            irq_o <= 1'b1;
            st    <= IRQ;
          end
        end
        IRQ: begin
          if (cpu_ack_i) begin
            irq_o       <= 1'b0;
            vec_valid_o <= 1'b1;
            vec_o       <= vec_r;
            src_ack_o   <= NB'(1) << vec_r;
            st          <= SVC;
          end else if (cnt == TO_W'(ACK_TO - 1)) begin
            // Withdraw but keep pend so the source is re-arbitrated.
            irq_o <= 1'b0;
            st    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SVC:   st <= INSVC;
        INSVC: if (eoi_i) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pic27_ack_ctrl.sv
// Directed bench for pic27_ack_ctrl with a behavioural priority-controller model.
module tb_pic27_ack_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] src_req;
  logic [8:0]  en;
  logic [8:0]  e_o, a_o, b_o, c_o;
  logic        pa, pb, pc;
  logic [3:0]  chan;
  logic        irq_o, cpu_ack, vec_valid_o, eoi, err_o;
  logic [4:0]  vec_o;
  logic [26:0] src_ack_o;
  logic        force_bad;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pic27_ack_ctrl #(.NCH(9), .ACK_TO(64), .TO_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .src_req_i(src_req), .en_i(en),
    .e_o(e_o), .a_o(a_o), .b_o(b_o), .c_o(c_o),
    .pa_i(pa), .pb_i(pb), .pc_i(pc), .chan_i(chan),
    .irq_o(irq_o), .cpu_ack_i(cpu_ack), .vec_valid_o(vec_valid_o),
    .vec_o(vec_o), .eoi_i(eoi), .src_ack_o(src_ack_o), .err_o(err_o)
  );

  function automatic logic [3:0] first_set(logic [8:0] v);
    logic [3:0] f = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) f = 4'(i);
    return f;
  endfunction

  // Priority controller: group A > B > C, lowest channel wins, code = 15-n.
  always_comb begin
    pa = 1'b0; pb = 1'b0; pc = 1'b0; chan = 4'd0;
    if (force_bad) begin
      pa = 1'b1; chan = 4'd4;
    end else if (|(a_o & e_o)) begin
      pa = 1'b1; chan = 4'd15 - first_set(a_o & e_o);
    end else if (|(b_o & e_o)) begin
      pb = 1'b1; chan = 4'd15 - first_set(b_o & e_o);
    end else if (|(c_o & e_o)) begin
      pc = 1'b1; chan = 4'd15 - first_set(c_o & e_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [26:0] m);
    @(negedge clk) src_req = src_req | m;
    @(negedge clk) src_req = src_req & ~m;
  endtask

  task automatic wait_irq(input string tag);
    int k = 0;
    while (!irq_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(irq_o), 32'd1);
  endtask

  // Full ack/SVC/EOI sequence; optional source edge and early EOI in the SVC cycle.
  task automatic service(input string tag, input logic [4:0] v,
                         input logic [26:0] svc_edge, input bit eoi_early);
    bit saw_irq = 0;
    wait_irq({tag, "_irq"});
    cpu_ack = 1'b1;
    @(negedge clk) cpu_ack = 1'b0;
    check({tag, "_valid"}, 32'(vec_valid_o), 32'd1);
    check({tag, "_vec"}, 32'(vec_o), 32'(v));
    check({tag, "_ack"}, 32'(src_ack_o), 32'(27'd1 << v));
    src_req = src_req | svc_edge;
    if (eoi_early) eoi = 1'b1;
    @(negedge clk);
    src_req = src_req & ~svc_edge;
    eoi = 1'b0;
    check({tag, "_valid_off"}, 32'(vec_valid_o), 32'd0);
    check({tag, "_ack_off"}, 32'(src_ack_o), 32'd0);
    if (eoi_early) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (irq_o) saw_irq = 1;
      end
      check({tag, "_insvc_hold"}, 32'(saw_irq), 32'd0);
    end
    eoi = 1'b1;
    @(negedge clk) eoi = 1'b0;
  endtask

  initial begin
    int  hi;
    bit  bad_irq, bad_ack;
    rst_n = 1'b0; src_req = '0; en = 9'h1FF; cpu_ack = 1'b0; eoi = 1'b0;
    force_bad = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_e", 32'(e_o), 32'd0);
    check("rst_pend", 32'({a_o, b_o, c_o}), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("e_reg", 32'(e_o), 32'h1FF);

    // Basic service of A3.
    pulse(27'd1 << 3);
    check("a3_pend", 32'(a_o), 32'h008);
    service("a3", 5'd3, '0, 0);
    check("a3_clear", 32'(a_o), 32'h000);

    // B1 beats C2; C2 served after EOI.
    pulse((27'd1 << 20) | (27'd1 << 10));
    service("b1", 5'd10, '0, 0);
    check("c2_left", 32'({b_o, c_o}), 32'({9'h000, 9'h004}));
    service("c2", 5'd20, '0, 0);

    // Ack timeout: irq held exactly 64 cycles, pend kept, irq re-raised.
    pulse(27'd1 << 4);
    wait_irq("to_irq");
    hi = 0;
    while (irq_o && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check("to_len", 32'(hi), 32'd64);
    check("to_pend", 32'(a_o), 32'h010);
    service("to_re", 5'd4, '0, 0);

    // Illegal channel code: sticky err, no irq, no ack.
    force_bad = 1'b1;
    pulse(27'd1 << 0);
    bad_irq = 0; bad_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq_o) bad_irq = 1;
      if (|src_ack_o) bad_ack = 1;
    end
    check("bad_err", 32'(err_o), 32'd1);
    check("bad_irq", 32'(bad_irq), 32'd0);
    check("bad_ack", 32'(bad_ack), 32'd0);
    force_bad = 1'b0;
    service("bad_rec", 5'd0, '0, 0);
    check("err_sticky", 32'(err_o), 32'd1);

    // New edge during SVC of the same bit survives the clear; early EOI ignored.
    pulse(27'd1 << 5);
    service("col", 5'd5, 27'd1 << 5, 1);
    check("col_pend", 32'(a_o), 32'h020);
    service("col2", 5'd5, '0, 0);

    // Asynchronous reset while in IRQ.
    pulse((27'd1 << 1) | (27'd1 << 19));
    wait_irq("ar_irq");
    #2 rst_n = 1'b0;
    #1;
    check("ar_irq_off", 32'(irq_o), 32'd0);
    check("ar_pend", 32'({a_o, b_o, c_o}), 32'd0);
    check("ar_err", 32'(err_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
